// File: rtl/matrix_pkg.sv
// Shared ALU opcodes, transpose FSM encoding and counter-width helper.
// Imported by the transpose unit and its storage sub-module.
package matrix_pkg;

    localparam logic [2:0] OP_ADD       = 3'b000;
    localparam logic [2:0] OP_SUB       = 3'b001;
    localparam logic [2:0] OP_MUL       = 3'b010;
    localparam logic [2:0] OP_SCALE     = 3'b011;
    localparam logic [2:0] OP_TRANSPOSE = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << bits) < value) begin
                bits = bits + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/transpose_store.sv
// DIMxDIM register array: row write port, combinational column read port.
// Write takes effect on the next posedge; read is zero-latency from registered storage.
module transpose_store
    import matrix_pkg::*;
#(
    parameter int DIM   = 4,
    parameter int WIDTH = 32,
    parameter int AW    = clog2(DIM)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [DIM*WIDTH-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic [DIM*WIDTH-1:0] rdata
);

    // Contents are not reset; the controller never exposes unwritten rows.
    logic [DIM*WIDTH-1:0] mem [DIM];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        for (int r = 0; r < DIM; r++) begin
            rdata[r*WIDTH +: WIDTH] = mem[r][int'(raddr)*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/matrix_transpose_buffer.sv
// Full-matrix transpose unit: loads DIM rows, then returns DIM columns; first column the cycle after the last row.
// Valid/ready on both sides; input stalls on InValid bubbles, output column held while OutReady is low.
module matrix_transpose_buffer
    import matrix_pkg::*;
#(
    parameter int         DIM    = 4,
    parameter int         WIDTH  = 32,
    parameter logic [2:0] OPCODE = OP_TRANSPOSE
) (
    input  logic                 Clock,
    input  logic                 ClearAll_n,
    input  logic [2:0]           Operation,
    input  logic                 Enable,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [DIM*WIDTH-1:0] InRow,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [DIM*WIDTH-1:0] OutRow,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Error
);

    localparam int            CW   = clog2(DIM);
    localparam logic [CW-1:0] LAST = CW'(DIM - 1);

    generate
        if (DIM < 2 || DIM > 16) begin : g_bad_dim
            $error("matrix_transpose_buffer: DIM must be in 2..16");
        end
    endgenerate

    state_t                 state, state_nxt;
    logic [CW-1:0]          rc, cc;
    logic [DIM*WIDTH-1:0]   col;
    logic                   start, in_hs, out_hs;

    assign start  = Enable && (Operation == OPCODE);
    assign in_hs  = InValid && InReady;
    assign out_hs = OutValid && OutReady;

    always_ff @(posedge Clock or negedge ClearAll_n) begin
        if (!ClearAll_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start)                state_nxt = ST_LOAD;
            ST_LOAD:  if (in_hs && rc == LAST)  state_nxt = ST_DRAIN;
            ST_DRAIN: if (out_hs && cc == LAST) state_nxt = ST_IDLE;
            default:                            state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        InReady  = (state == ST_LOAD);
        OutValid = (state == ST_DRAIN);
        Busy     = (state == ST_LOAD) || (state == ST_DRAIN);
        OutRow   = (state == ST_DRAIN) ? col : '0;
    end

    always_ff @(posedge Clock or negedge ClearAll_n) begin
        if (!ClearAll_n) begin
            rc <= '0;
            cc <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                rc <= '0;
            end else if (in_hs && rc != LAST) begin
                rc <= rc + 1'b1;
            end
            if (in_hs && rc == LAST) begin
                cc <= '0;
            end else if (out_hs && cc != LAST) begin
                cc <= cc + 1'b1;
            end
        end
    end

    // A start seen while busy (including the final drain beat) is dropped and flagged.
    always_ff @(posedge Clock or negedge ClearAll_n) begin
        if (!ClearAll_n) begin
            Done  <= 1'b0;
            Error <= 1'b0;
        end else begin
            Done <= out_hs && (cc == LAST);
            if (state == ST_IDLE && start) begin
                Error <= 1'b0;
            end else if (start) begin
                Error <= 1'b1;
            end
        end
    end

    transpose_store #(
        .DIM   (DIM),
        .WIDTH (WIDTH),
        .AW    (CW)
    ) u_store (
        .clk   (Clock),
        .we    (in_hs),
        .waddr (rc),
        .wdata (InRow),
        .raddr (cc),
        .rdata (col)
    );

endmodule
